// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and IF/ID outputs.
interface fetch_stage_if;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        misalign;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output hazard, branch_taken, branch_target, instr_in,
    input  pc, id_pc, id_instr, id_valid, misalign, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard, branch_taken, branch_target, instr_in,
    output pc, id_pc, id_instr, id_valid, misalign, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, IF/ID register, stall/redirect handling and event counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.slave bus
);
  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;
  logic        id_valid_q;
  logic        misalign_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      id_pc_q     <= '0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        BOOT: begin
          // First word is fetched unconditionally; controls are not yet meaningful.
          state      <= RUN;
          id_pc_q    <= RESET_PC;
          id_instr_q <= bus.instr_in;
          id_valid_q <= 1'b1;
          pc_q       <= RESET_PC + 32'd4;
        end
        RUN: begin
          if (bus.branch_taken) begin
            pc_q       <= {bus.branch_target[31:2], 2'b00};
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
            misalign_q <= |bus.branch_target[1:0];
            if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 16'd1;
          end else if (bus.hazard) begin
            if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 16'd1;
          end else begin
            pc_q       <= pc_q + 32'd4;
            id_pc_q    <= pc_q;
            id_instr_q <= bus.instr_in;
            id_valid_q <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.misalign  = misalign_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage with a simple instruction-memory model (instr = pc ^ 0xA5A50000).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk;
  logic reset;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.instr_in = bus.pc ^ KEY;

  typedef struct {
    logic        rst;
    logic        hz;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_idpc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_mis;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, hz, br, input logic [31:0] tgt, e_pc, e_idpc, e_instr,
                     input logic e_valid, e_mis, input logic [15:0] e_sc, e_fc);
    vec_t v;
    v.rst = rst; v.hz = hz; v.br = br; v.tgt = tgt;
    v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_instr = e_instr;
    v.e_valid = e_valid; v.e_mis = e_mis; v.e_sc = e_sc; v.e_fc = e_fc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pc"}, bus.pc, 32'h0);
    chk({tag, " id_pc"}, bus.id_pc, 32'h0);
    chk({tag, " id_instr"}, bus.id_instr, NOP);
    chk({tag, " id_valid"}, {31'b0, bus.id_valid}, 32'h0);
    chk({tag, " misalign"}, {31'b0, bus.misalign}, 32'h0);
    chk({tag, " stall_cnt"}, {16'b0, bus.stall_cnt}, 32'h0);
    chk({tag, " flush_cnt"}, {16'b0, bus.flush_cnt}, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.hazard = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;

    //  rst hz br  target        pc            id_pc         id_instr          v  m  sc  fc
    add(1, 0, 0, 32'h0,          32'h0,        32'h0,        NOP,              0, 0, 0, 0);
    add(0, 0, 0, 32'h0,          32'h4,        32'h0,        32'hA5A5_0000,    1, 0, 0, 0);
    add(0, 0, 0, 32'h0,          32'h8,        32'h4,        32'hA5A5_0004,    1, 0, 0, 0);
    add(0, 0, 0, 32'h0,          32'hC,        32'h8,        32'hA5A5_0008,    1, 0, 0, 0);
    add(1, 0, 0, 32'h0,          32'h0,        32'h0,        NOP,              0, 0, 0, 0);
    add(0, 0, 0, 32'h0,          32'h4,        32'h0,        32'hA5A5_0000,    1, 0, 0, 0);
    add(0, 0, 0, 32'h0,          32'h8,        32'h4,        32'hA5A5_0004,    1, 0, 0, 0);
    add(0, 1, 0, 32'h0,          32'h8,        32'h4,        32'hA5A5_0004,    1, 0, 1, 0);
    add(0, 0, 0, 32'h0,          32'hC,        32'h8,        32'hA5A5_0008,    1, 0, 1, 0);
    add(0, 1, 1, 32'h100,        32'h100,      32'h0,        NOP,              0, 0, 1, 1);
    add(0, 0, 0, 32'h0,          32'h104,      32'h100,      32'hA5A5_0100,    1, 0, 1, 1);
    add(0, 0, 1, 32'h203,        32'h200,      32'h0,        NOP,              0, 1, 1, 2);
    add(0, 0, 0, 32'h0,          32'h204,      32'h200,      32'hA5A5_0200,    1, 0, 1, 2);
    add(0, 0, 1, 32'hFFFF_FFF8,  32'hFFFF_FFF8, 32'h0,       NOP,              0, 0, 1, 3);
    add(0, 0, 0, 32'h0,          32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h5A5A_FFF8,  1, 0, 1, 3);
    add(0, 0, 0, 32'h0,          32'h0,        32'hFFFF_FFFC, 32'h5A5A_FFFC,   1, 0, 1, 3);
    add(0, 0, 0, 32'h0,          32'h4,        32'h0,        32'hA5A5_0000,    1, 0, 1, 3);
    add(1, 1, 0, 32'h0,          32'h0,        32'h0,        NOP,              0, 0, 0, 0);
    add(0, 1, 1, 32'h40,         32'h4,        32'h0,        32'hA5A5_0000,    1, 0, 0, 0);
    add(1, 0, 1, 32'h41,         32'h0,        32'h0,        NOP,              0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset             = vecs[i].rst;
      bus.hazard        = vecs[i].hz;
      bus.branch_taken  = vecs[i].br;
      bus.branch_target = vecs[i].tgt;
      step();
      chk($sformatf("v%0d pc", i), bus.pc, vecs[i].e_pc);
      chk($sformatf("v%0d id_pc", i), bus.id_pc, vecs[i].e_idpc);
      chk($sformatf("v%0d id_instr", i), bus.id_instr, vecs[i].e_instr);
      chk($sformatf("v%0d id_valid", i), {31'b0, bus.id_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d misalign", i), {31'b0, bus.misalign}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d stall_cnt", i), {16'b0, bus.stall_cnt}, {16'b0, vecs[i].e_sc});
      chk($sformatf("v%0d flush_cnt", i), {16'b0, bus.flush_cnt}, {16'b0, vecs[i].e_fc});
    end

    // Long stall: counter must saturate and hold, then reset mid-stall clears everything.
    reset = 1'b1; bus.hazard = 1'b0; bus.branch_taken = 1'b0; step();
    reset = 1'b0; step();
    bus.hazard = 1'b1;
    for (int n = 0; n < 65534; n++) step();
    chk("sat pre-limit stall_cnt", {16'b0, bus.stall_cnt}, 32'h0000_FFFE);
    step();
    chk("sat at-limit stall_cnt", {16'b0, bus.stall_cnt}, 32'h0000_FFFF);
    for (int n = 0; n < 4465; n++) step();
    chk("sat hold stall_cnt", {16'b0, bus.stall_cnt}, 32'h0000_FFFF);
    chk("sat hold pc", bus.pc, 32'h4);
    chk("sat hold id_pc", bus.id_pc, 32'h0);
    chk("sat hold id_instr", bus.id_instr, 32'hA5A5_0000);
    chk("sat hold id_valid", {31'b0, bus.id_valid}, 32'h1);
    reset = 1'b1;
    step();
    chk_reset_state("mid-stall reset");
    reset = 1'b0; bus.hazard = 1'b0;
    step();
    chk("post-reset boot pc", bus.pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
